// File: rtl/seg7_stopwatch_display.sv
// seg7_stopwatch_display: converts a binary tenths-of-second count into four
// active-low 7-segment digits. The conversion uses a sequential shift-add-3
// (double-dabble) engine that takes WIDTH+2 cycles, and the display blinks
// while blink_mode is nonzero.
// Optional build macro: SEG7_LEAD_BLANK_EN blanks leading-zero digits in
// dis3..dis1. dis0 always shows its digit.
module seg7_stopwatch_display #(
  parameter int WIDTH      = 14,
  parameter int BLINK_HALF = 25000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] number,
  input  logic [1:0]       blink_mode,
  output logic [6:0]       dis0,
  output logic [6:0]       dis1,
  output logic [6:0]       dis2,
  output logic [6:0]       dis3,
  output logic             upd
);

  localparam int SCW = $clog2(WIDTH + 1);
  localparam int BCW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] shreg_reg;
  logic [15:0]      bcd_reg;
  logic [SCW-1:0]   step_reg;
  logic             oor_reg;
  logic             upd_reg;
  logic [6:0]       hold_reg [4];
  logic [6:0]       dis_reg  [4];
  logic [BCW-1:0]   blink_cnt_reg;
  logic [BCW-1:0]   blink_cnt_next;
  logic             blank_phase_reg;
  logic             blank_phase_next;

  logic [15:0]         bcd_adj;
  logic [WIDTH+15:0]   shift_next;
  logic [3:0]          digit    [4];
  logic [6:0]          new_code [4];
  logic [3:0]          lead_zero;

  // Segment lookup for one BCD digit (active-low, codes as listed for the board)
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b0000001;
      4'd1:    seg_code = 7'b1001111;
      4'd2:    seg_code = 7'b0010010;
      4'd3:    seg_code = 7'b0000110;
      4'd4:    seg_code = 7'b1001100;
      4'd5:    seg_code = 7'b0100100;
      4'd6:    seg_code = 7'b0100000;
      4'd7:    seg_code = 7'b0001111;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0000100;
      default: seg_code = SEG_DASH;
    endcase
  endfunction

  // Per-digit add-3 correction and segment encoding of the finished BCD value
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
      assign digit[gi]    = bcd_reg[4*gi +: 4];
      assign new_code[gi] = oor_reg       ? SEG_DASH  :
                            lead_zero[gi] ? SEG_BLANK : seg_code(digit[gi]);
    end
  endgenerate

  assign shift_next = {bcd_adj, shreg_reg} << 1;

  // Leading-zero mask: scan from the thousands digit down, never the units
  always_comb begin
    lead_zero = 4'b0000;
`ifdef SEG7_LEAD_BLANK_EN
    lead_zero[3] = (digit[3] == 4'd0);
    lead_zero[2] = lead_zero[3] && (digit[2] == 4'd0);
    lead_zero[1] = lead_zero[2] && (digit[1] == 4'd0);
`endif
  end

  // Blink timer next state: held at zero and visible while steady
  always_comb begin
    blink_cnt_next   = '0;
    blank_phase_next = 1'b0;
    if (blink_mode != 2'd0) begin
      if (blink_cnt_reg == BCW'(BLINK_HALF - 1)) begin
        blink_cnt_next   = '0;
        blank_phase_next = ~blank_phase_reg;
      end else begin
        blink_cnt_next   = blink_cnt_reg + 1'b1;
        blank_phase_next = blank_phase_reg;
      end
    end
  end

  // Conversion FSM: capture, WIDTH shift-add-3 steps, then load the digits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      bcd_reg   <= '0;
      step_reg  <= '0;
      oor_reg   <= 1'b0;
      upd_reg   <= 1'b0;
      for (int i = 0; i < 4; i++) hold_reg[i] <= SEG_BLANK;
    end else begin
      upd_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          shreg_reg <= number;
          bcd_reg   <= '0;
          step_reg  <= '0;
          oor_reg   <= (32'(number) > 32'd9999);
          state_reg <= SHIFT;
        end
        SHIFT: begin
          {bcd_reg, shreg_reg} <= shift_next;
          step_reg <= step_reg + 1'b1;
          if (step_reg == SCW'(WIDTH - 1)) state_reg <= LOAD;
        end
        LOAD: begin
          for (int i = 0; i < 4; i++) hold_reg[i] <= new_code[i];
          upd_reg   <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Blink counter and phase registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_reg   <= '0;
      blank_phase_reg <= 1'b0;
    end else begin
      blink_cnt_reg   <= blink_cnt_next;
      blank_phase_reg <= blank_phase_next;
    end
  end

  // Registered digit outputs: fresh result on LOAD, blanked in the dark phase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) dis_reg[i] <= SEG_BLANK;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (blank_phase_next)
          dis_reg[i] <= SEG_BLANK;
        else if (state_reg == LOAD)
          dis_reg[i] <= new_code[i];
        else
          dis_reg[i] <= hold_reg[i];
      end
    end
  end

  assign dis0 = dis_reg[0];
  assign dis1 = dis_reg[1];
  assign dis2 = dis_reg[2];
  assign dis3 = dis_reg[3];
  assign upd  = upd_reg;

endmodule
